proc_feeder: RTL and testbench

- Instruction-issuing initiator for the 9-bit bus processor.
- Fetches 9-bit words from a synchronous-read program memory and drives the processor's DIN/Run inputs.
- Waits on the processor's Done for each instruction, and supplies the immediate word for mvi.
- Sits between program ROM and processor; it is the only source of DIN/Run in the system.

---
 rtl/proc_feeder.sv | 166 ++++++++++++++++
 tb/tb_proc_feeder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_feeder.sv
// proc_feeder: fetches program words and issues them to the 9-bit bus processor.
// Optional Done watchdog is compiled in by defining FEEDER_TIMEOUT_EN.
module proc_feeder #(
  parameter int            AW             = 8,
  parameter logic [AW-1:0] START_ADDR     = '0,
  parameter logic [2:0]    OP_MVI         = 3'b001,
  parameter logic [2:0]    OP_HALT        = 3'b111,
  parameter int            TIMEOUT_CYCLES = 64
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  output logic          MemRd,
  output logic [AW-1:0] MemAddr,
  input  logic [8:0]    MemData,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [15:0]   InstrCount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAITI,
    FETCHIMM,
    WAITIMM,
    ISSUE,
    EXEC,
    HALT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_n;
  logic [AW-1:0] addr_n;
  logic [8:0]    instr;
  logic [8:0]    instr_n;
  logic [8:0]    imm;
  logic [8:0]    imm_n;
  logic [8:0]    din_n;
  logic [15:0]   cnt_n;
  logic          rd_n;
  logic          run_n;
  logic          restart;
  logic          wd_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign restart = Start && (state == IDLE || state == HALT);
  assign Busy    = !(state == IDLE || state == HALT);
  assign Halted  = (state == HALT);

`ifdef FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd;
  logic           err;

  assign wd_hit = (state == EXEC) && !Done &&
                  (wd == WDW'(TIMEOUT_CYCLES - 1));
  assign Error  = err;

  // wd counts EXEC cycles; it is zero on every entry to EXEC
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= (state == EXEC) ? wd + WDW'(1) : '0;
      if (restart)
        err <= 1'b0;
      else if (wd_hit)
        err <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign Error  = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      pc         <= '0;
      instr      <= '0;
      imm        <= '0;
      InstrCount <= '0;
      MemRd      <= 1'b0;
      MemAddr    <= '0;
      DIN        <= '0;
      Run        <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr      <= instr_n;
      imm        <= imm_n;
      InstrCount <= cnt_n;
      MemRd      <= rd_n;
      MemAddr    <= addr_n;
      DIN        <= din_n;
      Run        <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (Start) state_n = FETCH;
      FETCH:    state_n = WAITI;
      WAITI: begin
        unique case (1'b1)
          MemData[8:6] == OP_HALT: state_n = HALT;
          MemData[8:6] == OP_MVI:  state_n = FETCHIMM;
          default:                 state_n = ISSUE;
        endcase
      end
      FETCHIMM: state_n = WAITIMM;
      WAITIMM:  state_n = ISSUE;
      ISSUE:    state_n = EXEC;
      EXEC: begin
        if (Done)
          state_n = FETCH;
        else if (wd_hit)
          state_n = HALT;
      end
      HALT:     if (Start) state_n = FETCH;
      default:  state_n = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered
  always_comb begin
    pc_n    = pc;
    instr_n = instr;
    imm_n   = imm;
    cnt_n   = InstrCount;
    if (restart) begin
      pc_n  = START_ADDR;
      cnt_n = '0;
    end
    if (state == FETCH || state == FETCHIMM)
      pc_n = pc + AW'(1);
    if (state == WAITI)
      instr_n = MemData;
    if (state == WAITIMM)
      imm_n = MemData;
    if (state == ISSUE && InstrCount != 16'hFFFF)
      cnt_n = InstrCount + 16'd1;
    rd_n   = (state_n == FETCH) || (state_n == FETCHIMM);
    addr_n = rd_n ? pc_n : MemAddr;
    run_n  = (state_n == ISSUE);
    din_n  = '0;
    if (state_n == ISSUE)
      din_n = instr_n;
    else if (state_n == EXEC && instr_n[8:6] == OP_MVI)
      din_n = imm_n;
  end

endmodule

// File: tb/tb_proc_feeder.sv
// Bench for proc_feeder: ROM and processor models plus an issue scoreboard.
// Watchdog scenario depends on FEEDER_TIMEOUT_EN.
module tb_proc_feeder;

  localparam int AW = 2;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic          MemRd;
  logic [AW-1:0] MemAddr;
  logic [8:0]    MemData;
  logic [8:0]    DIN;
  logic          Run;
  logic          Done;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [15:0]   InstrCount;

  typedef struct {
    logic [8:0] word;
    logic [8:0] exec_din;
  } iss_t;

  iss_t       exp_q[$];
  logic [8:0] rom [4];
  int         checks = 0;
  int         failures = 0;
  int         done_delay = 1;
  int         pend;

  proc_feeder #(
    .AW(AW),
    .START_ADDR(2'd0),
    .OP_MVI(3'b001),
    .OP_HALT(3'b111),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .MemRd(MemRd),
    .MemAddr(MemAddr),
    .MemData(MemData),
    .DIN(DIN),
    .Run(Run),
    .Done(Done),
    .Busy(Busy),
    .Halted(Halted),
    .Error(Error),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock)
    if (MemRd) MemData <= rom[MemAddr];

  // Processor: Done pulses done_delay EXEC cycles after Run; 0 = never
  always @(negedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pend <= 0;
      Done <= 1'b0;
    end else if (Run) begin
      pend <= done_delay;
      Done <= 1'b0;
    end else if (pend == 1) begin
      pend <= 0;
      Done <= 1'b1;
    end else begin
      if (pend > 1) pend <= pend - 1;
      Done <= 1'b0;
    end
  end

  task automatic reset_dut();
    Resetn = 1'b0;
    Start  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic start_pulse();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_run(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Run === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({MemRd, Run, Busy, Halted, Error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b want 00000",
               {MemRd, Run, Busy, Halted, Error});
    end
    checks++;
    if (DIN !== 9'd0) begin
      failures++;
      $display("FAIL reset_din got %o want 0", DIN);
    end
    checks++;
    if (MemAddr !== 2'd0) begin
      failures++;
      $display("FAIL reset_addr got %0d want 0", MemAddr);
    end
    checks++;
    if (InstrCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got %0d want 0", InstrCount);
    end
  endtask

  task automatic test_mv();
    int   n;
    bit   ok;
    iss_t e;
    rom[0] = 9'o012; rom[1] = 9'o700;
    rom[2] = 9'o000; rom[3] = 9'o000;
    done_delay = 1;
    exp_q.push_back('{9'o012, 9'o000});
    start_pulse();
    checks++;
    if ({MemRd, MemAddr, Busy} !== {1'b1, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL mv_fetch got rd=%b addr=%0d busy=%b want 1 0 1",
               MemRd, MemAddr, Busy);
    end
    wait_run(n, ok);
    checks++;
    if (!ok || n != 2) begin
      failures++;
      $display("FAIL mv_latency got %0d ok=%b want 2", n, ok);
    end
    e = exp_q.pop_front();
    checks++;
    if (DIN !== e.word) begin
      failures++;
      $display("FAIL mv_din got %o want %o", DIN, e.word);
    end
    @(negedge Clock);
    checks++;
    if ({Run, DIN, InstrCount} !== {1'b0, e.exec_din, 16'd1}) begin
      failures++;
      $display("FAIL mv_exec got run=%b din=%o cnt=%0d want 0 %o 1",
               Run, DIN, InstrCount, e.exec_din);
    end
    @(negedge Clock);
    checks++;
    if ({MemRd, MemAddr} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL mv_next_fetch got rd=%b addr=%0d want 1 1",
               MemRd, MemAddr);
    end
    repeat (2) @(negedge Clock);
    checks++;
    if ({Halted, Busy, Run, DIN} !== {3'b100, 9'd0}) begin
      failures++;
      $display("FAIL mv_halt got h=%b b=%b r=%b din=%o want 1 0 0 0",
               Halted, Busy, Run, DIN);
    end
  endtask

  task automatic test_mvi_halt();
    int   n;
    bit   ok;
    bit   quiet;
    iss_t e;
    rom[0] = 9'o110; rom[1] = 9'o005;
    rom[2] = 9'o700; rom[3] = 9'o000;
    done_delay = 1;
    exp_q.push_back('{9'o110, 9'o005});
    start_pulse();
    checks++;
    if ({MemRd, MemAddr, InstrCount} !== {1'b1, 2'd0, 16'd0}) begin
      failures++;
      $display("FAIL restart got rd=%b addr=%0d cnt=%0d want 1 0 0",
               MemRd, MemAddr, InstrCount);
    end
    wait_run(n, ok);
    checks++;
    if (!ok || n != 4) begin
      failures++;
      $display("FAIL mvi_latency got %0d ok=%b want 4", n, ok);
    end
    e = exp_q.pop_front();
    checks++;
    if (DIN !== e.word) begin
      failures++;
      $display("FAIL mvi_din got %o want %o", DIN, e.word);
    end
    @(negedge Clock);
    checks++;
    if ({Run, DIN} !== {1'b0, e.exec_din}) begin
      failures++;
      $display("FAIL mvi_imm got run=%b din=%o want 0 %o",
               Run, DIN, e.exec_din);
    end
    @(negedge Clock);
    checks++;
    if ({MemRd, MemAddr} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL mvi_next_fetch got rd=%b addr=%0d want 1 2",
               MemRd, MemAddr);
    end
    repeat (2) @(negedge Clock);
    quiet = 1'b1;
    repeat (6) begin
      if (Run !== 1'b0 || MemRd !== 1'b0 || Halted !== 1'b1 ||
          Busy !== 1'b0 || DIN !== 9'd0)
        quiet = 1'b0;
      @(negedge Clock);
    end
    checks++;
    if (!quiet || InstrCount !== 16'd1) begin
      failures++;
      $display("FAIL halt_quiet got quiet=%b cnt=%0d want 1 1",
               quiet, InstrCount);
    end
  endtask

  task automatic test_add_wait();
    int   n;
    bit   ok;
    bit   hold;
    iss_t e;
    rom[0] = 9'o201; rom[1] = 9'o700;
    rom[2] = 9'o000; rom[3] = 9'o000;
    done_delay = 3;
    exp_q.push_back('{9'o201, 9'o000});
    start_pulse();
    wait_run(n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || DIN !== e.word) begin
      failures++;
      $display("FAIL add_din got %o ok=%b want %o", DIN, ok, e.word);
    end
    hold = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      if (MemRd !== 1'b0 || Run !== 1'b0 || Busy !== 1'b1 ||
          DIN !== e.exec_din)
        hold = 1'b0;
    end
    checks++;
    if (!hold) begin
      failures++;
      $display("FAIL add_hold got activity during wait want none");
    end
    @(negedge Clock);
    checks++;
    if ({MemRd, MemAddr} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL add_next_fetch got rd=%b addr=%0d want 1 1",
               MemRd, MemAddr);
    end
    repeat (2) @(negedge Clock);
    checks++;
    if ({Halted, InstrCount} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL add_halt got h=%b cnt=%0d want 1 1",
               Halted, InstrCount);
    end
  endtask

  task automatic test_wrap();
    int   n;
    bit   ok;
    iss_t e;
    rom[0] = 9'o012; rom[1] = 9'o012;
    rom[2] = 9'o012; rom[3] = 9'o110;
    done_delay = 1;
    exp_q.push_back('{9'o012, 9'o000});
    exp_q.push_back('{9'o012, 9'o000});
    exp_q.push_back('{9'o012, 9'o000});
    exp_q.push_back('{9'o110, 9'o012});
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      wait_run(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || DIN !== e.word) begin
        failures++;
        $display("FAIL wrap_din[%0d] got %o ok=%b want %o",
                 k, DIN, ok, e.word);
      end
      @(negedge Clock);
      checks++;
      if (DIN !== e.exec_din) begin
        failures++;
        $display("FAIL wrap_exec[%0d] got %o want %o",
                 k, DIN, e.exec_din);
      end
    end
    @(negedge Clock);
    checks++;
    if ({MemRd, MemAddr} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL wrap_pc got rd=%b addr=%0d want 1 1",
               MemRd, MemAddr);
    end
  endtask

  task automatic test_timeout();
    int   n;
    bit   ok;
    iss_t e;
    reset_dut();
    rom[0] = 9'o201; rom[1] = 9'o700;
    rom[2] = 9'o000; rom[3] = 9'o000;
    done_delay = 0;
    exp_q.push_back('{9'o201, 9'o000});
    start_pulse();
    wait_run(n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || DIN !== e.word) begin
      failures++;
      $display("FAIL to_issue got %o ok=%b want %o", DIN, ok, e.word);
    end
`ifdef FEEDER_TIMEOUT_EN
    repeat (4) @(negedge Clock);
    checks++;
    if ({Halted, Error, Busy} !== 3'b001) begin
      failures++;
      $display("FAIL to_early got h=%b e=%b b=%b want 0 0 1",
               Halted, Error, Busy);
    end
    @(negedge Clock);
    checks++;
    if ({Halted, Error, Busy, DIN} !== {3'b110, 9'd0}) begin
      failures++;
      $display("FAIL to_fire got h=%b e=%b b=%b din=%o want 1 1 0 0",
               Halted, Error, Busy, DIN);
    end
    start_pulse();
    checks++;
    if ({Error, MemRd} !== 2'b01) begin
      failures++;
      $display("FAIL to_clear got e=%b rd=%b want 0 1", Error, MemRd);
    end
    wait_run(n, ok);
    @(negedge Clock);
`else
    repeat (20) @(negedge Clock);
    checks++;
    if ({Busy, Halted, Error, MemRd, Run} !== 5'b10000) begin
      failures++;
      $display("FAIL no_timeout got %b want 10000",
               {Busy, Halted, Error, MemRd, Run});
    end
`endif
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if ({MemRd, MemAddr, DIN, Run, Busy, Halted, Error, InstrCount}
        !== '0) begin
      failures++;
      $display("FAIL async_reset got rd=%b a=%0d d=%o r=%b b=%b h=%b e=%b c=%0d want all 0",
               MemRd, MemAddr, DIN, Run, Busy, Halted, Error, InstrCount);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mv();
    test_mvi_halt();
    test_add_wait();
    test_wrap();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
